// File: rtl/apb_sram_pkg.sv
// Shared constants and depth/address helpers for the APB SRAM slave.
package apb_sram_pkg;

  localparam int unsigned LSRAM      = 0;
  localparam int unsigned USRAM      = 1;
  localparam int unsigned APB_AWIDTH = 20;

  // Pick the word count for the selected memory type and data width.
  function automatic int unsigned depth_sel(
    input int unsigned sel,
    input int unsigned dwidth,
    input int unsigned l32,
    input int unsigned l24,
    input int unsigned l16,
    input int unsigned l08,
    input int unsigned u32,
    input int unsigned u24,
    input int unsigned u16,
    input int unsigned u08
  );
    case (dwidth)
      32:      return (sel == USRAM) ? u32 : l32;
      24:      return (sel == USRAM) ? u24 : l24;
      16:      return (sel == USRAM) ? u16 : l16;
      default: return (sel == USRAM) ? u08 : l08;
    endcase
  endfunction

  // Byte-to-word address shift for a given data width.
  function automatic int unsigned addr_shift(input int unsigned dwidth);
    case (dwidth)
      32, 24:  return 2;
      16:      return 1;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/apb_sram_mem.sv
// Single-port synchronous RAM with registered read; the read register clears
// on reset and returns zero for reads flagged as misses.
module apb_sram_mem #(
  parameter int unsigned DEPTH  = 512,
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned AWIDTH = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic              rd_hit,
  input  logic [AWIDTH-1:0] addr,
  input  logic [DWIDTH-1:0] wr_data,
  output logic [DWIDTH-1:0] rd_data
);

  logic [DWIDTH-1:0] mem_q [DEPTH];

  // Array has no reset so it maps onto a RAM macro.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= rd_hit ? mem_q[addr] : '0;
    end
  end

endmodule

// File: rtl/apb_sram_slave.sv
// APB3 zero-wait-state scratch SRAM slave.
// Optional macro APB_SRAM_SLVERR_EN flags out-of-range accesses on PSLVERR.
module apb_sram_slave
  import apb_sram_pkg::*;
#(
  parameter int unsigned SEL_SRAM_TYPE               = 0,
  parameter int unsigned APB_DWIDTH                  = 32,
  parameter int unsigned LSRAM_NUM_LOCATIONS_DWIDTH32 = 512,
  parameter int unsigned LSRAM_NUM_LOCATIONS_DWIDTH24 = 512,
  parameter int unsigned LSRAM_NUM_LOCATIONS_DWIDTH16 = 1024,
  parameter int unsigned LSRAM_NUM_LOCATIONS_DWIDTH08 = 2048,
  parameter int unsigned USRAM_NUM_LOCATIONS_DWIDTH32 = 64,
  parameter int unsigned USRAM_NUM_LOCATIONS_DWIDTH24 = 64,
  parameter int unsigned USRAM_NUM_LOCATIONS_DWIDTH16 = 128,
  parameter int unsigned USRAM_NUM_LOCATIONS_DWIDTH08 = 256
) (
  input  logic                  PCLK,
  input  logic                  PRESETN,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [APB_AWIDTH-1:0] PADDR,
  input  logic [APB_DWIDTH-1:0] PWDATA,
  output logic [APB_DWIDTH-1:0] PRDATA,
  output logic                  PSLVERR,
  output logic                  PREADY
);

  localparam int unsigned DEPTH = depth_sel(SEL_SRAM_TYPE, APB_DWIDTH,
    LSRAM_NUM_LOCATIONS_DWIDTH32, LSRAM_NUM_LOCATIONS_DWIDTH24,
    LSRAM_NUM_LOCATIONS_DWIDTH16, LSRAM_NUM_LOCATIONS_DWIDTH08,
    USRAM_NUM_LOCATIONS_DWIDTH32, USRAM_NUM_LOCATIONS_DWIDTH24,
    USRAM_NUM_LOCATIONS_DWIDTH16, USRAM_NUM_LOCATIONS_DWIDTH08);
  localparam int unsigned SHIFT = addr_shift(APB_DWIDTH);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [APB_AWIDTH-1:0] idx_full_c;
  logic                  in_range_c;
  logic                  rd_en_c;
  logic                  wr_en_c;

  assign idx_full_c = PADDR >> SHIFT;
  assign in_range_c = (idx_full_c < APB_AWIDTH'(DEPTH));
  assign rd_en_c    = PSEL & ~PENABLE & ~PWRITE;
  // Reset gates the write so an access aborted by reset never commits.
  assign wr_en_c    = PSEL & PENABLE & PWRITE & in_range_c & PRESETN;
  assign PREADY     = 1'b1;

  apb_sram_mem #(
    .DEPTH  (DEPTH),
    .DWIDTH (APB_DWIDTH),
    .AWIDTH (IDX_W)
  ) u_mem (
    .clk     (PCLK),
    .rst_n   (PRESETN),
    .wr_en   (wr_en_c),
    .rd_en   (rd_en_c),
    .rd_hit  (in_range_c),
    .addr    (idx_full_c[IDX_W-1:0]),
    .wr_data (PWDATA),
    .rd_data (PRDATA)
  );

`ifdef APB_SRAM_SLVERR_EN
  // Set at the setup edge, cleared at the access edge: high for the access phase.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      PSLVERR <= 1'b0;
    end else begin
      PSLVERR <= PSEL & ~PENABLE & ~in_range_c;
    end
  end
`else
  assign PSLVERR = 1'b0;
`endif

endmodule

// File: tb/tb_apb_sram_slave.sv
// Directed bench for apb_sram_slave across 32-bit LSRAM, 16-bit uSRAM and 8-bit LSRAM builds.
module tb_apb_sram_slave;

  logic        PCLK;
  logic        PRESETN;
  logic        PENABLE;
  logic        PWRITE;
  logic [19:0] PADDR;
  logic [31:0] PWDATA;
  logic        psel0, psel1, psel2;
  logic [31:0] prdata0;
  logic [15:0] prdata1;
  logic [7:0]  prdata2;
  logic        pslverr0, pslverr1, pslverr2;
  logic        pready0, pready1, pready2;

  int checks = 0;
  int errors = 0;

`ifdef APB_SRAM_SLVERR_EN
  localparam logic OOR_ERR = 1'b1;
`else
  localparam logic OOR_ERR = 1'b0;
`endif

  apb_sram_slave #(.SEL_SRAM_TYPE(0), .APB_DWIDTH(32)) u_dut32 (
    .PCLK(PCLK), .PRESETN(PRESETN), .PSEL(psel0), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(prdata0),
    .PSLVERR(pslverr0), .PREADY(pready0)
  );

  apb_sram_slave #(.SEL_SRAM_TYPE(1), .APB_DWIDTH(16)) u_dut16 (
    .PCLK(PCLK), .PRESETN(PRESETN), .PSEL(psel1), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA[15:0]), .PRDATA(prdata1),
    .PSLVERR(pslverr1), .PREADY(pready1)
  );

  apb_sram_slave #(.SEL_SRAM_TYPE(0), .APB_DWIDTH(8)) u_dut8 (
    .PCLK(PCLK), .PRESETN(PRESETN), .PSEL(psel2), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA[7:0]), .PRDATA(prdata2),
    .PSLVERR(pslverr2), .PREADY(pready2)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rd_of(input int d);
    case (d)
      0:       return prdata0;
      1:       return 32'(prdata1);
      default: return 32'(prdata2);
    endcase
  endfunction

  function automatic logic err_of(input int d);
    case (d)
      0:       return pslverr0;
      1:       return pslverr1;
      default: return pslverr2;
    endcase
  endfunction

  // One two-cycle transfer starting at a negedge; samples PRDATA/PSLVERR in the access phase.
  task automatic xfer(input int d, input logic wr, input logic [19:0] addr,
                      input logic [31:0] wdata, output logic [31:0] rdata,
                      output logic slverr);
    PADDR   = addr;
    PWRITE  = wr;
    PWDATA  = wdata;
    PENABLE = 1'b0;
    psel0   = (d == 0);
    psel1   = (d == 1);
    psel2   = (d == 2);
    @(negedge PCLK);
    PENABLE = 1'b1;
    rdata   = rd_of(d);
    slverr  = err_of(d);
    @(negedge PCLK);
    psel0   = 1'b0;
    psel1   = 1'b0;
    psel2   = 1'b0;
    PENABLE = 1'b0;
  endtask

  logic [31:0] rd;
  logic        se;
  logic [31:0] exp;

  initial begin
    PRESETN = 1'b0;
    PENABLE = 1'b0;
    PWRITE  = 1'b0;
    PADDR   = '0;
    PWDATA  = '0;
    psel0   = 1'b0;
    psel1   = 1'b0;
    psel2   = 1'b0;
    repeat (3) @(negedge PCLK);
    check("rst_prdata32", prdata0, 32'h0);
    check("rst_prdata16", 32'(prdata1), 32'h0);
    check("rst_slverr", 32'(pslverr0), 32'h0);
    check("rst_pready", 32'({pready0, pready1, pready2}), 32'h7);
    PRESETN = 1'b1;
    @(negedge PCLK);

    // Width 32, LSRAM, depth 512
    for (int unsigned a = 0; a < 2048; a += 4)
      xfer(0, 1'b1, 20'(a), 32'(a + (a << 16)), rd, se);
    for (int unsigned a = 0; a < 2048; a += 4) begin
      xfer(0, 1'b0, 20'(a), 32'h0, rd, se);
      check("rd32", rd, 32'(a + (a << 16)));
    end
    xfer(0, 1'b0, 20'h8, 32'h0, rd, se);
    check("rd32_addr8", rd, 32'h0008_0008);
    check("slverr_inrange", 32'(se), 32'h0);

    // Width 16, uSRAM, depth 128
    for (int unsigned a = 0; a < 256; a += 2)
      xfer(1, 1'b1, 20'(a), 32'(a + (a << 16)), rd, se);
    for (int unsigned a = 0; a < 256; a += 2) begin
      xfer(1, 1'b0, 20'(a), 32'h0, rd, se);
      check("rd16", rd, a & 32'hFFFF);
    end
    xfer(1, 1'b0, 20'h6, 32'h0, rd, se);
    check("rd16_addr6", rd, 32'h0006);

    // Width 8, LSRAM, depth 2048
    for (int unsigned a = 0; a < 2048; a++)
      xfer(2, 1'b1, 20'(a), 32'(a + (a << 16)), rd, se);
    for (int unsigned a = 0; a < 2048; a++) begin
      xfer(2, 1'b0, 20'(a), 32'h0, rd, se);
      check("rd8", rd, a & 32'hFF);
    end
    xfer(2, 1'b0, 20'h1FF, 32'h0, rd, se);
    check("rd8_addr1ff", rd, 32'hFF);

    // Out of range at width 32: 0x800 is word 512
    xfer(0, 1'b1, 20'h800, 32'hCAFE_F00D, rd, se);
    check("oor_wr_slverr", 32'(se), 32'(OOR_ERR));
    xfer(0, 1'b0, 20'h800, 32'h0, rd, se);
    check("oor_rd_data", rd, 32'h0);
    check("oor_rd_slverr", 32'(se), 32'(OOR_ERR));
    xfer(0, 1'b0, 20'h0, 32'h0, rd, se);
    check("oor_no_alias", rd, 32'h0);
    check("after_oor_slverr", 32'(se), 32'h0);

    // Back-to-back write then reads, low address bits ignored
    xfer(0, 1'b1, 20'h10, 32'hDEAD_BEEF, rd, se);
    xfer(0, 1'b0, 20'h10, 32'h0, rd, se);
    check("b2b_rd_10", rd, 32'hDEAD_BEEF);
    xfer(0, 1'b0, 20'h11, 32'h0, rd, se);
    check("b2b_rd_11", rd, 32'hDEAD_BEEF);
    @(negedge PCLK);
    check("prdata_hold_idle", prdata0, 32'hDEAD_BEEF);
    xfer(0, 1'b1, 20'h14, 32'h1234_5678, rd, se);
    check("prdata_hold_write", rd, 32'hDEAD_BEEF);
    check("prdata_after_write", prdata0, 32'hDEAD_BEEF);
    xfer(0, 1'b0, 20'h14, 32'h0, rd, se);
    check("rd_14", rd, 32'h1234_5678);

    // Reset asserted during a write access must abort the write
    xfer(0, 1'b1, 20'h20, 32'h1111_1111, rd, se);
    PADDR   = 20'h20;
    PWRITE  = 1'b1;
    PWDATA  = 32'h2222_2222;
    PENABLE = 1'b0;
    psel0   = 1'b1;
    @(negedge PCLK);
    PENABLE = 1'b1;
    PRESETN = 1'b0;
    @(negedge PCLK);
    psel0   = 1'b0;
    PENABLE = 1'b0;
    check("midrst_prdata", prdata0, 32'h0);
    check("midrst_slverr", 32'(pslverr0), 32'h0);
    check("midrst_pready", 32'(pready0), 32'h1);
    @(negedge PCLK);
    PRESETN = 1'b1;
    @(negedge PCLK);
    xfer(0, 1'b0, 20'h20, 32'h0, rd, se);
    exp = 32'h1111_1111;
    check("midrst_old_data", rd, exp);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
